// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared VGA timing defaults, derived totals and coordinate type
package vga_pkg;

  typedef logic [9:0] coord_t;

  localparam int unsigned DEF_CLK_DIV   = 2;
  localparam int unsigned DEF_H_VISIBLE = 640;
  localparam int unsigned DEF_H_FRONT   = 16;
  localparam int unsigned DEF_H_SYNC    = 96;
  localparam int unsigned DEF_H_BACK    = 48;
  localparam int unsigned DEF_V_VISIBLE = 480;
  localparam int unsigned DEF_V_FRONT   = 10;
  localparam int unsigned DEF_V_SYNC    = 2;
  localparam int unsigned DEF_V_BACK    = 33;
  localparam bit          DEF_SYNC_NEG  = 1'b1;
  localparam int unsigned MAX_TOTAL     = 1024;

  function automatic int unsigned axis_total(input int unsigned vis, input int unsigned front,
                                             input int unsigned sync, input int unsigned back);
    return vis + front + sync + back;
  endfunction

  localparam int unsigned DEF_H_TOTAL =
    axis_total(DEF_H_VISIBLE, DEF_H_FRONT, DEF_H_SYNC, DEF_H_BACK);
  localparam int unsigned DEF_V_TOTAL =
    axis_total(DEF_V_VISIBLE, DEF_V_FRONT, DEF_V_SYNC, DEF_V_BACK);

endpackage

// File: rtl/vga_timing_gen_if.sv
// rtl/vga_timing_gen_if.sv - raster timing bundle from the generator to display consumers
interface vga_timing_gen_if;
  import vga_pkg::*;

  logic       pix_en;
  coord_t     h_readwire;
  coord_t     v_readwire;
  logic       hsync;
  logic       vsync;
  logic       display_active;
  logic       line_end;
  logic       frame_start;
  logic       vblank_start;
  logic [7:0] frame_count;

  modport master (
    output pix_en, h_readwire, v_readwire, hsync, vsync, display_active,
           line_end, frame_start, vblank_start, frame_count
  );

  modport slave (
    input pix_en, h_readwire, v_readwire, hsync, vsync, display_active,
          line_end, frame_start, vblank_start, frame_count
  );

endinterface

// File: rtl/vga_axis_counter.sv
// rtl/vga_axis_counter.sv - one raster axis: wrapping counter with registered sync/visible decode
module vga_axis_counter
  import vga_pkg::*;
#(
  parameter int unsigned TOTAL      = DEF_H_TOTAL,
  parameter int unsigned SYNC_START = DEF_H_VISIBLE + DEF_H_FRONT,
  parameter int unsigned SYNC_END   = DEF_H_VISIBLE + DEF_H_FRONT + DEF_H_SYNC,
  parameter int unsigned VISIBLE    = DEF_H_VISIBLE
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   tick,
  output coord_t count,
  output coord_t count_next,
  output logic   wrap,
  output logic   sync_active,
  output logic   visible
);

  localparam coord_t LAST    = coord_t'(TOTAL - 1);
  localparam coord_t S_START = coord_t'(SYNC_START);
  localparam coord_t S_END   = coord_t'(SYNC_END);
  localparam coord_t VIS     = coord_t'(VISIBLE);

  coord_t count_q, count_d;
  logic   sync_q, sync_d;
  logic   visible_q, visible_d;

  // Decoding count_d keeps sync/visible aligned with the count they describe.
  always_comb begin
    count_d   = count_q;
    wrap      = 1'b0;
    if (tick) begin
      if (count_q == LAST) begin
        count_d = '0;
        wrap    = 1'b1;
      end else begin
        count_d = count_q + coord_t'(1);
      end
    end
    sync_d    = (count_d >= S_START) && (count_d < S_END);
    visible_d = (count_d < VIS);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q   <= '0;
      sync_q    <= 1'b0;
      visible_q <= 1'b0;
    end else begin
      count_q   <= count_d;
      sync_q    <= sync_d;
      visible_q <= visible_d;
    end
  end

  assign count       = count_q;
  assign count_next  = count_d;
  assign sync_active = sync_q;
  assign visible     = visible_q;

endmodule

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - VGA raster timing: pixel enable, h/v counters, syncs, strobes, frame count
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int unsigned CLK_DIV   = DEF_CLK_DIV,
  parameter int unsigned H_VISIBLE = DEF_H_VISIBLE,
  parameter int unsigned H_FRONT   = DEF_H_FRONT,
  parameter int unsigned H_SYNC    = DEF_H_SYNC,
  parameter int unsigned H_BACK    = DEF_H_BACK,
  parameter int unsigned V_VISIBLE = DEF_V_VISIBLE,
  parameter int unsigned V_FRONT   = DEF_V_FRONT,
  parameter int unsigned V_SYNC    = DEF_V_SYNC,
  parameter int unsigned V_BACK    = DEF_V_BACK,
  parameter bit          SYNC_NEG  = DEF_SYNC_NEG
) (
  input  logic              clk,
  input  logic              rst_n,
  vga_timing_gen_if.master  vif
);

  localparam int unsigned H_TOTAL = axis_total(H_VISIBLE, H_FRONT, H_SYNC, H_BACK);
  localparam int unsigned V_TOTAL = axis_total(V_VISIBLE, V_FRONT, V_SYNC, V_BACK);
  localparam logic [2:0]  DIV_LAST = 3'(CLK_DIV - 1);
  localparam coord_t      H_LAST   = coord_t'(H_TOTAL - 1);
  localparam coord_t      V_VIS_C  = coord_t'(V_VISIBLE);

  if (H_TOTAL > MAX_TOTAL || V_TOTAL > MAX_TOTAL || CLK_DIV < 1 || CLK_DIV > 8) begin : g_bad_timing
    $error("vga_timing_gen: totals must be <= 1024 and CLK_DIV within 1..8");
  end

  logic [2:0] div_q, div_d;
  logic       pix_en_q, pix_en_d;
  logic       line_end_q, line_end_d;
  logic       frame_start_q, frame_start_d;
  logic       vblank_start_q, vblank_start_d;
  logic [7:0] frame_count_q, frame_count_d;

  coord_t h_count, h_next, v_count, v_next;
  logic   h_wrap, v_wrap, h_sync, v_sync, h_vis, v_vis;

  vga_axis_counter #(
    .TOTAL      (H_TOTAL),
    .SYNC_START (H_VISIBLE + H_FRONT),
    .SYNC_END   (H_VISIBLE + H_FRONT + H_SYNC),
    .VISIBLE    (H_VISIBLE)
  ) u_h (
    .clk (clk), .rst_n (rst_n), .tick (pix_en_q),
    .count (h_count), .count_next (h_next), .wrap (h_wrap),
    .sync_active (h_sync), .visible (h_vis)
  );

  vga_axis_counter #(
    .TOTAL      (V_TOTAL),
    .SYNC_START (V_VISIBLE + V_FRONT),
    .SYNC_END   (V_VISIBLE + V_FRONT + V_SYNC),
    .VISIBLE    (V_VISIBLE)
  ) u_v (
    .clk (clk), .rst_n (rst_n), .tick (h_wrap),
    .count (v_count), .count_next (v_next), .wrap (v_wrap),
    .sync_active (v_sync), .visible (v_vis)
  );

  // pix_en_d is next cycle's enable, so strobes register alongside the counters they decode.
  always_comb begin
    div_d          = (div_q == DIV_LAST) ? 3'd0 : div_q + 3'd1;
    pix_en_d       = (div_q == DIV_LAST);
    line_end_d     = pix_en_d && (h_next == H_LAST);
    frame_start_d  = pix_en_d && (h_next == '0) && (v_next == '0);
    vblank_start_d = pix_en_d && (h_next == '0) && (v_next == V_VIS_C);
    frame_count_d  = frame_count_q + {7'd0, v_wrap};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q          <= 3'd0;
      pix_en_q       <= 1'b0;
      line_end_q     <= 1'b0;
      frame_start_q  <= 1'b0;
      vblank_start_q <= 1'b0;
      frame_count_q  <= 8'd0;
    end else begin
      div_q          <= div_d;
      pix_en_q       <= pix_en_d;
      line_end_q     <= line_end_d;
      frame_start_q  <= frame_start_d;
      vblank_start_q <= vblank_start_d;
      frame_count_q  <= frame_count_d;
    end
  end

  assign vif.pix_en         = pix_en_q;
  assign vif.h_readwire     = h_count;
  assign vif.v_readwire     = v_count;
  assign vif.hsync          = h_sync ^ SYNC_NEG;
  assign vif.vsync          = v_sync ^ SYNC_NEG;
  assign vif.display_active = h_vis & v_vis;
  assign vif.line_end       = line_end_q;
  assign vif.frame_start    = frame_start_q;
  assign vif.vblank_start   = vblank_start_q;
  assign vif.frame_count    = frame_count_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - directed self-checking bench for vga_timing_gen on a reduced raster
module tb_vga_timing_gen;

  localparam int DIV = 2;
  localparam int HV = 6, HF = 1, HS = 3, HB = 2;
  localparam int VV = 3, VF = 1, VS = 2, VB = 1;
  localparam int HT = HV + HF + HS + HB;
  localparam int VT = VV + VF + VS + VB;
  localparam int FRAME = HT * VT;

  typedef struct packed {
    logic       pe;
    logic [9:0] h;
    logic [9:0] v;
    logic       hs;
    logic       vs;
    logic       act;
    logic       le;
    logic       fs;
    logic       vb;
    logic [7:0] fc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n;
  int   checks = 0;
  int   fails = 0;

  vga_timing_gen_if vif ();
  vga_timing_gen_if vif1 ();

  vga_timing_gen #(
    .CLK_DIV (DIV),
    .H_VISIBLE (HV), .H_FRONT (HF), .H_SYNC (HS), .H_BACK (HB),
    .V_VISIBLE (VV), .V_FRONT (VF), .V_SYNC (VS), .V_BACK (VB),
    .SYNC_NEG (1'b1)
  ) dut (
    .clk (clk), .rst_n (rst_n), .vif (vif)
  );

  vga_timing_gen #(
    .CLK_DIV (1)
  ) dut1 (
    .clk (clk), .rst_n (rst_n), .vif (vif1)
  );

  always #5 clk = ~clk;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) n <= 0;
    else        n <= n + 1;
  end

  function automatic exp_t model(input int k);
    exp_t e;
    int p, hi, vi;
    p  = (k == 0) ? 0 : (k - 1) / DIV;
    hi = p % HT;
    vi = (p / HT) % VT;
    e.pe  = (k >= 1) && (k % DIV == 0);
    e.h   = 10'(hi);
    e.v   = 10'(vi);
    e.hs  = !((hi >= HV + HF) && (hi < HV + HF + HS));
    e.vs  = !((vi >= VV + VF) && (vi < VV + VF + VS));
    e.act = (k >= 1) && (hi < HV) && (vi < VV);
    e.le  = e.pe && (hi == HT - 1);
    e.fs  = e.pe && (hi == 0) && (vi == 0);
    e.vb  = e.pe && (hi == 0) && (vi == VV);
    e.fc  = 8'((p / FRAME) % 256);
    return e;
  endfunction

  function automatic exp_t snap();
    return {vif.pix_en, vif.h_readwire, vif.v_readwire, vif.hsync, vif.vsync,
            vif.display_active, vif.line_end, vif.frame_start, vif.vblank_start,
            vif.frame_count};
  endfunction

  task automatic test_reset();
    exp_t o;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    o = snap();
    checks++; if (o.pe !== 1'b0)  begin fails++; $display("FAIL reset_pix_en: got %b expected 0", o.pe); end
    checks++; if (o.h !== 10'd0)  begin fails++; $display("FAIL reset_h: got %0d expected 0", o.h); end
    checks++; if (o.v !== 10'd0)  begin fails++; $display("FAIL reset_v: got %0d expected 0", o.v); end
    checks++; if (o.hs !== 1'b1)  begin fails++; $display("FAIL reset_hsync: got %b expected 1", o.hs); end
    checks++; if (o.vs !== 1'b1)  begin fails++; $display("FAIL reset_vsync: got %b expected 1", o.vs); end
    checks++; if (o.act !== 1'b0) begin fails++; $display("FAIL reset_active: got %b expected 0", o.act); end
    checks++; if ({o.le, o.fs, o.vb} !== 3'b000) begin
      fails++; $display("FAIL reset_strobes: got %b expected 000", {o.le, o.fs, o.vb});
    end
    checks++; if (o.fc !== 8'd0)  begin fails++; $display("FAIL reset_frame_count: got %0d expected 0", o.fc); end
  endtask

  task automatic test_release();
    exp_t o;
    rst_n = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      o = snap();
      checks++;
      if (o.pe !== ((i % 2) == 0)) begin
        fails++; $display("FAIL release_pix_en clk %0d: got %b expected %b", i, o.pe, (i % 2) == 0);
      end
      if (i == 2) begin
        checks++;
        if ({o.fs, o.h, o.v} !== {1'b1, 10'd0, 10'd0}) begin
          fails++; $display("FAIL first_frame_start: got fs=%b h=%0d v=%0d expected fs=1 h=0 v=0", o.fs, o.h, o.v);
        end
      end
    end
  endtask

  task automatic test_div1();
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      checks++;
      if (vif1.pix_en !== 1'b1 || vif1.h_readwire !== 10'(n - 1)) begin
        fails++; $display("FAIL div1_pix_en_h: got pe=%b h=%0d expected pe=1 h=%0d", vif1.pix_en, vif1.h_readwire, n - 1);
      end
    end
  endtask

  task automatic test_line();
    exp_t o, e;
    int hs_cnt = 0, le_cnt = 0;
    for (int i = 0; i < HT * DIV; i++) begin
      @(negedge clk);
      o = snap();
      e = model(n);
      checks++;
      if ({o.h, o.hs, o.le} !== {e.h, e.hs, e.le}) begin
        fails++; $display("FAIL line_cycle n=%0d: got h=%0d hs=%b le=%b expected h=%0d hs=%b le=%b",
                          n, o.h, o.hs, o.le, e.h, e.hs, e.le);
      end
      if (o.pe && !o.hs) hs_cnt++;
      if (o.le) le_cnt++;
    end
    checks++; if (hs_cnt != HS) begin fails++; $display("FAIL line_hsync_width: got %0d expected %0d", hs_cnt, HS); end
    checks++; if (le_cnt != 1)  begin fails++; $display("FAIL line_end_count: got %0d expected 1", le_cnt); end
  endtask

  task automatic test_frame();
    exp_t o, e;
    int pe_cnt = 0, act_cnt = 0, vb_cnt = 0, vs_cnt = 0;
    bit found = 0, closed = 0;
    for (int i = 0; i < FRAME * DIV + 4; i++) begin
      @(negedge clk);
      if (vif.frame_start) begin found = 1; break; end
    end
    checks++; if (!found) begin fails++; $display("FAIL frame_start_wait: got timeout expected pulse"); end
    for (int i = 0; i < FRAME * DIV + 4; i++) begin
      o = snap();
      e = model(n);
      checks++;
      if (o !== e) begin fails++; $display("FAIL frame_cycle n=%0d: got %h expected %h", n, o, e); end
      if (o.pe) pe_cnt++;
      if (o.pe && o.act) act_cnt++;
      if (o.pe && !o.vs) vs_cnt++;
      if (o.vb) begin
        vb_cnt++;
        checks++;
        if ({o.h, o.v} !== {10'd0, 10'(VV)}) begin
          fails++; $display("FAIL vblank_pos: got h=%0d v=%0d expected h=0 v=%0d", o.h, o.v, VV);
        end
      end
      @(negedge clk);
      if (vif.frame_start) begin closed = 1; break; end
    end
    checks++; if (!closed)          begin fails++; $display("FAIL frame_end_wait: got timeout expected pulse"); end
    checks++; if (pe_cnt != FRAME)  begin fails++; $display("FAIL frame_pix_count: got %0d expected %0d", pe_cnt, FRAME); end
    checks++; if (act_cnt != HV*VV) begin fails++; $display("FAIL frame_active_count: got %0d expected %0d", act_cnt, HV * VV); end
    checks++; if (vs_cnt != VS*HT)  begin fails++; $display("FAIL frame_vsync_pixels: got %0d expected %0d", vs_cnt, VS * HT); end
    checks++; if (vb_cnt != 1)      begin fails++; $display("FAIL vblank_count: got %0d expected 1", vb_cnt); end
    checks++; if (vif.frame_count !== 8'd2) begin fails++; $display("FAIL frame_count_after: got %0d expected 2", vif.frame_count); end
  endtask

  task automatic test_corner();
    exp_t e;
    bit found = 0;
    for (int i = 0; i < FRAME * DIV + 4; i++) begin
      @(negedge clk);
      e = model(n);
      if (e.pe && e.h == 10'(HT - 1) && e.v == 10'(VT - 1)) begin found = 1; break; end
    end
    checks++;
    if (!found || vif.line_end !== 1'b1 || vif.h_readwire !== 10'(HT - 1) || vif.v_readwire !== 10'(VT - 1)) begin
      fails++; $display("FAIL corner_line_end: got le=%b h=%0d v=%0d expected le=1 h=%0d v=%0d",
                        vif.line_end, vif.h_readwire, vif.v_readwire, HT - 1, VT - 1);
    end
    repeat (DIV) @(negedge clk);
    checks++;
    if ({vif.pix_en, vif.frame_start, vif.h_readwire, vif.v_readwire} !== {1'b1, 1'b1, 10'd0, 10'd0}) begin
      fails++; $display("FAIL corner_wrap: got pe=%b fs=%b h=%0d v=%0d expected pe=1 fs=1 h=0 v=0",
                        vif.pix_en, vif.frame_start, vif.h_readwire, vif.v_readwire);
    end
  endtask

  task automatic test_async_reset();
    exp_t o, r;
    bit found = 0;
    for (int i = 0; i < FRAME * DIV + 4; i++) begin
      @(negedge clk);
      if (vif.h_readwire == 10'd5 && vif.v_readwire == 10'd2) begin found = 1; break; end
    end
    checks++; if (!found) begin fails++; $display("FAIL async_reach_point: got timeout expected h=5 v=2"); end
    #2 rst_n = 1'b0;
    #1;
    o = snap();
    r = '0;
    r.hs = 1'b1;
    r.vs = 1'b1;
    checks++; if (o !== r) begin fails++; $display("FAIL async_reset_values: got %h expected %h", o, r); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (vif.pix_en !== 1'b0) begin fails++; $display("FAIL restart_first_clk_pix_en: got %b expected 0", vif.pix_en); end
    @(negedge clk);
    checks++;
    if ({vif.pix_en, vif.frame_start, vif.h_readwire, vif.v_readwire} !== {1'b1, 1'b1, 10'd0, 10'd0}) begin
      fails++; $display("FAIL restart_origin: got pe=%b fs=%b h=%0d v=%0d expected pe=1 fs=1 h=0 v=0",
                        vif.pix_en, vif.frame_start, vif.h_readwire, vif.v_readwire);
    end
  endtask

  task automatic test_frame_wrap();
    exp_t e;
    bit done = 0;
    for (int i = 0; i < 50000; i++) begin
      @(negedge clk);
      e = model(n);
      checks++;
      if (vif.frame_count !== e.fc) begin
        fails++; $display("FAIL wrap_frame_count n=%0d: got %0d expected %0d", n, vif.frame_count, e.fc);
      end
      if ((n - 1) / DIV >= 256 * FRAME) begin done = 1; break; end
    end
    checks++;
    if (!done || vif.frame_count !== 8'd0 || vif.h_readwire !== 10'd0 || vif.v_readwire !== 10'd0) begin
      fails++; $display("FAIL wrap_256_frames: got fc=%0d h=%0d v=%0d expected fc=0 h=0 v=0",
                        vif.frame_count, vif.h_readwire, vif.v_readwire);
    end
  endtask

  initial begin
    test_reset();
    test_release();
    test_div1();
    test_line();
    test_frame();
    test_corner();
    test_async_reset();
    test_frame_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
